imem_arbiter: RTL and testbench

- Shares one single-port, synchronous-read instruction memory (32-bit words) between two requesters: the core fetch stage and the program loader/debug port.
- The loader writes program images and reads them back. The fetch stage reads instructions.
- Requests use a req/gnt handshake. Read data returns with fixed 1-cycle latency. A loader lock supports uninterrupted bursts.
- Sits between the core front end and the instruction memory model.

---
 rtl/imem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_imem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Two-requester arbiter (core fetch, program loader) for a single-port synchronous-read
// instruction memory. Optional fetch starvation guard enabled by IMEM_STARVE_GUARD_EN.
module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 20,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // fetch port
  input  logic                  i_f_req,
  input  logic [31:0]           i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  output logic [31:0]           o_f_rdata,
  output logic                  o_f_err,
  // loader port
  input  logic                  i_l_req,
  input  logic                  i_l_we,
  input  logic [31:0]           i_l_addr,
  input  logic [31:0]           i_l_wdata,
  input  logic                  i_l_lock,
  output logic                  o_l_gnt,
  output logic                  o_l_rvalid,
  output logic [31:0]           o_l_rdata,
  // memory port
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  logic [1:0] state_q, state_d;

  logic f_ok, l_ok;
  logic locked;
  logic force_f;
  logic f_gnt_raw, l_gnt_raw;
  logic f_gnt, l_gnt;
  logic mem_en, mem_we;

  logic        f_rvalid_q, f_err_q;
  logic [31:0] f_rdata_q;
  logic        l_rvalid_q, l_bad_q;
  logic [31:0] l_rdata_q;

  // Word aligned and no address bits above the memory's word range.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (ADDR_WIDTH + 2)) == 32'd0);
  endfunction

  assign f_ok = addr_ok(i_f_addr);
  assign l_ok = addr_ok(i_l_addr);

  // ---------------------------------------------------------------------------
  // Starvation guard
  // ---------------------------------------------------------------------------
`ifdef IMEM_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_f = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (f_gnt_raw) begin
      starve_d = '0;
    end else if (i_f_req && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_f = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign locked = (state_q == LOAD) && i_l_lock;

  // A held lock shuts fetch out unless the starvation guard fires.
  assign f_gnt_raw = i_f_req && (!locked || force_f);
  assign l_gnt_raw = i_l_req && !f_gnt_raw;

  always_comb begin
    state_d = IDLE;
    if (locked) begin
      state_d = LOAD;
    end else if (f_gnt_raw) begin
      state_d = FETCH;
    end else if (l_gnt_raw) begin
      state_d = LOAD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants and memory strobes are forced low while reset is held.
  assign f_gnt  = i_rst_n && f_gnt_raw;
  assign l_gnt  = i_rst_n && l_gnt_raw;
  assign mem_en = (f_gnt && f_ok) || (l_gnt && l_ok);
  assign mem_we = l_gnt && l_ok && i_l_we;

  assign o_f_gnt     = f_gnt;
  assign o_l_gnt     = l_gnt;
  assign o_mem_en    = mem_en;
  assign o_mem_we    = mem_we;
  assign o_mem_wdata = mem_we ? i_l_wdata : 32'd0;

  always_comb begin
    o_mem_addr = '0;
    if (f_gnt && f_ok) begin
      o_mem_addr = i_f_addr[ADDR_WIDTH+1:2];
    end else if (l_gnt && l_ok) begin
      o_mem_addr = i_l_addr[ADDR_WIDTH+1:2];
    end
  end

  // ---------------------------------------------------------------------------
  // Responses
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      f_rdata_q  <= 32'd0;
      l_rvalid_q <= 1'b0;
      l_bad_q    <= 1'b0;
      l_rdata_q  <= 32'd0;
    end else begin
      f_rvalid_q <= f_gnt && f_ok;
      f_err_q    <= f_gnt && !f_ok;
      l_rvalid_q <= l_gnt && !i_l_we;
      l_bad_q    <= !l_ok;
      if (f_rvalid_q) begin
        f_rdata_q <= i_mem_rdata;
      end
      if (l_rvalid_q) begin
        l_rdata_q <= l_bad_q ? 32'd0 : i_mem_rdata;
      end
    end
  end

  // Memory data arrives one cycle after the grant; pass it straight through on the
  // valid cycle and hold the captured copy afterwards.
  assign o_f_rvalid = f_rvalid_q;
  assign o_f_err    = f_err_q;
  assign o_f_rdata  = f_rvalid_q ? i_mem_rdata : f_rdata_q;

  assign o_l_rvalid = l_rvalid_q;
  assign o_l_rdata  = l_rvalid_q ? (l_bad_q ? 32'd0 : i_mem_rdata) : l_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised bench for imem_arbiter against a cycle-level reference model of the
// arbitration rules and a 64-word memory image.
module tb_imem_arbiter;

  localparam int unsigned AW    = 20;
  localparam int unsigned LIMIT = 3;
`ifdef IMEM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_f_req;
  logic [31:0]   i_f_addr;
  logic          o_f_gnt;
  logic          o_f_rvalid;
  logic [31:0]   o_f_rdata;
  logic          o_f_err;
  logic          i_l_req;
  logic          i_l_we;
  logic [31:0]   i_l_addr;
  logic [31:0]   i_l_wdata;
  logic          i_l_lock;
  logic          o_l_gnt;
  logic          o_l_rvalid;
  logic [31:0]   o_l_rdata;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  imem_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_f_req    (i_f_req),
    .i_f_addr   (i_f_addr),
    .o_f_gnt    (o_f_gnt),
    .o_f_rvalid (o_f_rvalid),
    .o_f_rdata  (o_f_rdata),
    .o_f_err    (o_f_err),
    .i_l_req    (i_l_req),
    .i_l_we     (i_l_we),
    .i_l_addr   (i_l_addr),
    .i_l_wdata  (i_l_wdata),
    .i_l_lock   (i_l_lock),
    .o_l_gnt    (o_l_gnt),
    .o_l_rvalid (o_l_rvalid),
    .o_l_rdata  (o_l_rdata),
    .o_mem_en   (o_mem_en),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Memory seen by the DUT (synchronous read).
  logic [31:0] tb_mem [64];
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) tb_mem[o_mem_addr[5:0]] = o_mem_wdata;
      else          i_mem_rdata <= tb_mem[o_mem_addr[5:0]];
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [64];
  bit          m_load;
  int unsigned m_starve;
  bit          e_f_rvalid, e_f_err, e_l_rvalid;
  logic [31:0] e_f_rdata, e_l_rdata;

  // DUT observations from the most recent cycle, for directed checks
  logic          d_f_gnt, d_l_gnt, d_mem_en, d_mem_we;
  logic [AW-1:0] d_mem_addr;

  task automatic model_reset();
    m_load     = 1'b0;
    m_starve   = 0;
    e_f_rvalid = 1'b0;
    e_f_err    = 1'b0;
    e_l_rvalid = 1'b0;
    e_f_rdata  = 32'd0;
    e_l_rdata  = 32'd0;
  endtask

  function automatic bit good_addr(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
  endfunction

  // One clock cycle: drive, check grants/memory strobes, then check responses.
  task automatic cycle(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                       input logic [31:0] la, input logic [31:0] ld, input bit lk);
    bit          f_ok, l_ok, locked, frc, gf, gl, en, we;
    logic [31:0] waddr;
    @(negedge i_clk);
    i_f_req   = fr;
    i_f_addr  = fa;
    i_l_req   = lr;
    i_l_we    = lw;
    i_l_addr  = la;
    i_l_wdata = ld;
    i_l_lock  = lk;
    #1;
    f_ok   = good_addr(fa);
    l_ok   = good_addr(la);
    locked = m_load && lk;
    frc    = GUARD && (m_starve == LIMIT);
    gf     = fr && (!locked || frc);
    gl     = lr && !gf;
    en     = (gf && f_ok) || (gl && l_ok);
    we     = gl && lw && l_ok;
    waddr  = gf ? {12'd0, fa[AW+1:2]} : {12'd0, la[AW+1:2]};
    d_f_gnt    = o_f_gnt;
    d_l_gnt    = o_l_gnt;
    d_mem_en   = o_mem_en;
    d_mem_we   = o_mem_we;
    d_mem_addr = o_mem_addr;
    chk("f_gnt", {31'd0, o_f_gnt}, {31'd0, gf});
    chk("l_gnt", {31'd0, o_l_gnt}, {31'd0, gl});
    chk("mem_en", {31'd0, o_mem_en}, {31'd0, en});
    chk("mem_we", {31'd0, o_mem_we}, {31'd0, we});
    if (en) chk("mem_addr", {12'd0, o_mem_addr}, waddr);
    if (we) chk("mem_wdata", o_mem_wdata, ld);
    // advance the model across the clock edge
    e_f_rvalid = gf && f_ok;
    e_f_err    = gf && !f_ok;
    e_l_rvalid = gl && !lw;
    if (gf && f_ok) e_f_rdata = ref_mem[fa[7:2]];
    if (gl && !lw) e_l_rdata = l_ok ? ref_mem[la[7:2]] : 32'd0;
    if (we) ref_mem[la[7:2]] = ld;
    if (gf) m_starve = 0;
    else if (fr && m_starve < LIMIT) m_starve++;
    if (!locked) m_load = !gf && gl;
    @(posedge i_clk);
    #1;
    chk("f_rvalid", {31'd0, o_f_rvalid}, {31'd0, e_f_rvalid});
    chk("f_err", {31'd0, o_f_err}, {31'd0, e_f_err});
    chk("f_rdata", o_f_rdata, e_f_rdata);
    chk("l_rvalid", {31'd0, o_l_rvalid}, {31'd0, e_l_rvalid});
    chk("l_rdata", o_l_rdata, e_l_rdata);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_gnt"}, {31'd0, o_f_gnt}, 32'd0);
    chk({tag, "_l_gnt"}, {31'd0, o_l_gnt}, 32'd0);
    chk({tag, "_f_rvalid"}, {31'd0, o_f_rvalid}, 32'd0);
    chk({tag, "_f_err"}, {31'd0, o_f_err}, 32'd0);
    chk({tag, "_f_rdata"}, o_f_rdata, 32'd0);
    chk({tag, "_l_rvalid"}, {31'd0, o_l_rvalid}, 32'd0);
    chk({tag, "_l_rdata"}, o_l_rdata, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, o_mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, o_mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {12'd0, o_mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    logic [5:0]  idx;
    int unsigned k;
    k   = $urandom_range(0, 9);
    idx = 6'($urandom_range(0, 63));
    a   = {24'd0, idx, 2'b00};
    if (k == 0)      a[1:0]     = 2'($urandom_range(1, 3));
    else if (k == 1) a[31:AW+2] = 10'($urandom_range(1, 1023));
    return a;
  endfunction

  initial begin : main
    int first_f;
    bit resumed;
    bit lk;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[4]  = 32'h2402_0005;
    ref_mem[4] = 32'h2402_0005;
    i_mem_rdata = 32'd0;
    i_rst_n   = 1'b0;
    i_f_req   = 1'b0;
    i_f_addr  = 32'd0;
    i_l_req   = 1'b0;
    i_l_we    = 1'b0;
    i_l_addr  = 32'd0;
    i_l_wdata = 32'd0;
    i_l_lock  = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Fetch read of word 4
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("t1_gnt", {31'd0, d_f_gnt}, 32'd1);
    chk("t1_addr", {12'd0, d_mem_addr}, 32'd4);
    chk("t1_rvalid", {31'd0, o_f_rvalid}, 32'd1);
    chk("t1_rdata", o_f_rdata, 32'h2402_0005);
    idle();

    // Simultaneous requests: fetch first, loader next cycle, then read back
    cycle(1'b1, 32'h0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0);
    chk("t2_n_fgnt", {31'd0, d_f_gnt}, 32'd1);
    chk("t2_n_lgnt", {31'd0, d_l_gnt}, 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0);
    chk("t2_n1_lgnt", {31'd0, d_l_gnt}, 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'd0, 1'b0);
    chk("t2_rd_rvalid", {31'd0, o_l_rvalid}, 32'd1);
    chk("t2_rd_rdata", o_l_rdata, 32'hDEAD_BEEF);

    // Bad addresses
    cycle(1'b1, 32'h6, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("t3_fgnt", {31'd0, d_f_gnt}, 32'd1);
    chk("t3_men", {31'd0, d_mem_en}, 32'd0);
    chk("t3_ferr", {31'd0, o_f_err}, 32'd1);
    chk("t3_frvalid", {31'd0, o_f_rvalid}, 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0040_0000, 32'd0, 1'b0);
    chk("t3_lmen", {31'd0, d_mem_en}, 32'd0);
    chk("t3_lrvalid", {31'd0, o_l_rvalid}, 32'd1);
    chk("t3_lrdata", o_l_rdata, 32'd0);
    idle();

    // Locked burst of four writes while fetch waits
    for (int i = 0; i < 4; i++) begin
      cycle(i != 0, 32'h20, 1'b1, 1'b1, 32'(i * 4), 32'hA5A5_0000 + 32'(i), 1'b1);
      chk("t4_lgnt", {31'd0, d_l_gnt}, 32'd1);
    end
    cycle(1'b1, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("t4_fgnt_after", {31'd0, d_f_gnt}, 32'd1);
    idle();

    // Loader locked for ten cycles with fetch requesting
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h1111_2222, 1'b1);
    first_f = -1;
    resumed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h40, 1'b1, 1'b1, 32'h30, 32'(i), 1'b1);
      if (d_f_gnt && first_f < 0) first_f = i;
      else if (first_f >= 0 && i == first_f + 1) resumed = d_l_gnt;
    end
    chk("t5_first_fgnt", 32'(first_f), GUARD ? 32'd3 : 32'hFFFF_FFFF);
    chk("t5_resume", {31'd0, resumed}, {31'd0, GUARD});
    idle();

    // Random traffic
    lk = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) lk = !lk;
      cycle($urandom_range(0, 9) < 6, rnd_addr(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, rnd_addr(), $urandom, lk);
    end
    idle();

    // Reset asserted in the cycle after a read grant
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) begin
      @(posedge i_clk);
      #1;
      chk_all_zero("rst_hold");
    end
    @(negedge i_clk);
    i_f_req = 1'b0;
    i_rst_n = 1'b1;
    model_reset();
    idle();
    chk("post_rst_rvalid", {31'd0, o_f_rvalid}, 32'd0);
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
